// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ISA opcodes, ALU operation codes, instruction classes and FSM state encoding
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_MUL  = 5'd3;
    localparam logic [4:0] ALU_DIV  = 5'd4;
    localparam logic [4:0] ALU_SHR  = 5'd5;
    localparam logic [4:0] ALU_SHL  = 5'd6;
    localparam logic [4:0] ALU_SHRA = 5'd7;
    localparam logic [4:0] ALU_ROR  = 5'd8;
    localparam logic [4:0] ALU_ROL  = 5'd9;
    localparam logic [4:0] ALU_AND  = 5'd10;
    localparam logic [4:0] ALU_OR   = 5'd11;
    localparam logic [4:0] ALU_NEG  = 5'd12;
    localparam logic [4:0] ALU_NOT  = 5'd15;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    typedef enum logic [3:0] {
        C_RALU, C_IMM, C_MULDIV, C_UNARY, C_LDI, C_LD, C_ST, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } iclass_t;

    // Final execute state of each instruction class; the FSM leaves after it.
    function automatic logic [3:0] last_state(input iclass_t c);
        return (c == C_LD || c == C_ST) ? S_T7 :
               (c == C_MULDIV || c == C_BR) ? S_T6 :
               (c == C_RALU || c == C_IMM || c == C_LDI) ? S_T5 :
               (c == C_UNARY || c == C_JAL) ? S_T4 : S_T3;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational map from ISA opcode to instruction class and ALU operation
module cu_decode
    import cpu_pkg::*;
(
    input  logic [4:0] isa_op_i,
    output iclass_t    cls_o,
    output logic [4:0] alu_op_o
);

    // Address-forming classes (ldi/ld/st/br) use the adder; non-ALU classes leave it at nop.
    always_comb begin
        cls_o    = C_NOP;
        alu_op_o = ALU_NOP;
        case (isa_op_i)
            OP_LD:   begin cls_o = C_LD;     alu_op_o = ALU_ADD;  end
            OP_LDI:  begin cls_o = C_LDI;    alu_op_o = ALU_ADD;  end
            OP_ST:   begin cls_o = C_ST;     alu_op_o = ALU_ADD;  end
            OP_ADD:  begin cls_o = C_RALU;   alu_op_o = ALU_ADD;  end
            OP_SUB:  begin cls_o = C_RALU;   alu_op_o = ALU_SUB;  end
            OP_AND:  begin cls_o = C_RALU;   alu_op_o = ALU_AND;  end
            OP_OR:   begin cls_o = C_RALU;   alu_op_o = ALU_OR;   end
            OP_SHR:  begin cls_o = C_RALU;   alu_op_o = ALU_SHR;  end
            OP_SHRA: begin cls_o = C_RALU;   alu_op_o = ALU_SHRA; end
            OP_SHL:  begin cls_o = C_RALU;   alu_op_o = ALU_SHL;  end
            OP_ROR:  begin cls_o = C_RALU;   alu_op_o = ALU_ROR;  end
            OP_ROL:  begin cls_o = C_RALU;   alu_op_o = ALU_ROL;  end
            OP_ADDI: begin cls_o = C_IMM;    alu_op_o = ALU_ADD;  end
            OP_ANDI: begin cls_o = C_IMM;    alu_op_o = ALU_AND;  end
            OP_ORI:  begin cls_o = C_IMM;    alu_op_o = ALU_OR;   end
            OP_MUL:  begin cls_o = C_MULDIV; alu_op_o = ALU_MUL;  end
            OP_DIV:  begin cls_o = C_MULDIV; alu_op_o = ALU_DIV;  end
            OP_NEG:  begin cls_o = C_UNARY;  alu_op_o = ALU_NEG;  end
            OP_NOT:  begin cls_o = C_UNARY;  alu_op_o = ALU_NOT;  end
            OP_BR:   begin cls_o = C_BR;     alu_op_o = ALU_ADD;  end
            OP_JR:   cls_o = C_JR;
            OP_JAL:  cls_o = C_JAL;
            OP_IN:   cls_o = C_IN;
            OP_OUT:  cls_o = C_OUT;
            OP_MFHI: cls_o = C_MFHI;
            OP_MFLO: cls_o = C_MFLO;
            OP_NOP:  cls_o = C_NOP;
            OP_HALT: cls_o = C_HALT;
            default: cls_o = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing fetch and per-class execute micro-steps of the CPU datapath
module control_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        run,
    output logic        PCout, MDRout, ZHighOut, ZLowOut, HIout, LOout, InPortOut, Cout, BAout, Rout,
    output logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONN_in, OutPortIn, InPortIn,
    output logic        Gra, Grb, Grc, read, write, incPC,
    output logic [4:0]  opcode
);

    logic [3:0]  state_q, state_d;
    logic [7:0]  t;
    logic [15:0] c;
    iclass_t     cls;
    logic [4:0]  alu_op;
    logic        addr, ldst, wb5, zop, brt;
    logic        unused_ok;

    cu_decode u_decode (
        .isa_op_i (ir[31:27]),
        .cls_o    (cls),
        .alu_op_o (alu_op)
    );

    assign t = {state_q == S_T7, state_q == S_T6, state_q == S_T5, state_q == S_T4,
                state_q == S_T3, state_q == S_T2, state_q == S_T1, state_q == S_T0};
    assign c = 16'(1) << cls;
    assign unused_ok = ^{ir[26:0], c[C_NOP]};

    // Step past fetch, leave after the class's last step (>= tolerates ir changing mid-execute), park in HALT.
    always_comb begin
        state_d = (state_q == S_HALT) ? S_HALT :
                  (state_q > S_HALT) ? S_IDLE :
                  (state_q >= S_T3 && state_q >= last_state(cls)) ?
                      ((c[C_HALT] && state_q == S_T3) ? S_HALT : S_T0) :
                  state_q + 4'd1;
    end

    // State register; clr low forces IDLE immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    assign addr = c[C_LDI] | c[C_LD] | c[C_ST];
    assign ldst = c[C_LD] | c[C_ST];
    assign wb5  = c[C_RALU] | c[C_IMM] | c[C_LDI];
    assign zop  = t[4] & (c[C_RALU] | c[C_IMM] | c[C_MULDIV] | addr) | t[3] & c[C_UNARY] | t[5] & c[C_BR];
    assign brt  = t[6] & c[C_BR] & con_ff;

    assign run       = state_q != S_HALT;
    assign PCout     = t[0] | t[4] & c[C_BR] | t[3] & c[C_JAL];
    assign MDRout    = t[2] | t[7] & c[C_LD];
    assign ZHighOut  = t[6] & c[C_MULDIV];
    assign ZLowOut   = t[1] | t[5] & (wb5 | c[C_MULDIV] | ldst) | t[4] & c[C_UNARY] | brt;
    assign HIout     = t[3] & c[C_MFHI];
    assign LOout     = t[3] & c[C_MFLO];
    assign InPortOut = t[3] & c[C_IN];
    assign Cout      = t[4] & (c[C_IMM] | addr) | t[5] & c[C_BR];
    assign BAout     = t[3] & addr;
    assign Rout      = t[3] & (c[C_RALU] | c[C_IMM] | c[C_MULDIV] | c[C_UNARY] | c[C_BR] | c[C_JR] | c[C_OUT])
                     | t[4] & (c[C_RALU] | c[C_MULDIV] | c[C_JAL]) | t[6] & c[C_ST];
    assign PCin      = t[1] | t[3] & c[C_JR] | t[4] & c[C_JAL] | brt;
    assign IRin      = t[2];
    assign MARin     = t[0] | t[5] & ldst;
    assign MDRin     = t[1] | t[6] & ldst;
    assign Yin       = t[3] & (c[C_RALU] | c[C_IMM] | c[C_MULDIV] | addr) | t[4] & c[C_BR];
    assign Zin       = t[0] | zop;
    assign HIin      = t[6] & c[C_MULDIV];
    assign LOin      = t[5] & c[C_MULDIV];
    assign Rin       = t[5] & wb5 | t[4] & c[C_UNARY] | t[7] & c[C_LD]
                     | t[3] & (c[C_JAL] | c[C_IN] | c[C_MFHI] | c[C_MFLO]);
    assign CONN_in   = t[3] & c[C_BR];
    assign OutPortIn = t[3] & c[C_OUT];
    assign InPortIn  = 1'b0;
    assign Gra       = t[5] & wb5 | t[4] & (c[C_UNARY] | c[C_JAL]) | t[7] & c[C_LD] | t[6] & c[C_ST]
                     | t[3] & (c[C_MULDIV] | c[C_BR] | c[C_JR] | c[C_IN] | c[C_OUT] | c[C_MFHI] | c[C_MFLO]);
    assign Grb       = t[3] & (c[C_RALU] | c[C_IMM] | c[C_UNARY] | addr | c[C_JAL]) | t[4] & c[C_MULDIV];
    assign Grc       = t[4] & c[C_RALU];
    assign read      = t[1] | t[6] & c[C_LD];
    assign write     = t[7] & c[C_ST];
    assign incPC     = t[0];
    assign opcode    = zop ? alu_op : ALU_NOP;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vector table, hand-written halt/reset sequences and randomized instructions vs a micro-step model
module tb_control_unit;

    logic        clk = 1'b0, clr = 1'b1, con_ff = 1'b0;
    logic [31:0] ir = '0;
    logic        run, PCout, MDRout, ZHighOut, ZLowOut, HIout, LOout, InPortOut, Cout, BAout, Rout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONN_in, OutPortIn, InPortIn;
    logic        Gra, Grb, Grc, read, write, incPC;
    logic [4:0]  opcode;
    logic [27:0] act;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .run(run),
        .PCout(PCout), .MDRout(MDRout), .ZHighOut(ZHighOut), .ZLowOut(ZLowOut), .HIout(HIout),
        .LOout(LOout), .InPortOut(InPortOut), .Cout(Cout), .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .Rin(Rin), .CONN_in(CONN_in), .OutPortIn(OutPortIn), .InPortIn(InPortIn),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .read(read), .write(write), .incPC(incPC), .opcode(opcode)
    );

    assign act = {InPortIn, OutPortIn, CONN_in, Rin, LOin, HIin, Zin, Yin, MDRin, MARin, IRin, PCin,
                  Rout, BAout, Cout, InPortOut, LOout, HIout, ZLowOut, ZHighOut, MDRout, PCout,
                  incPC, write, read, Grc, Grb, Gra};

    localparam logic [27:0] GRA = 28'(1) << 0, GRB = 28'(1) << 1, GRC = 28'(1) << 2, READ = 28'(1) << 3;
    localparam logic [27:0] WRITE = 28'(1) << 4, INCPC = 28'(1) << 5, PCOUT = 28'(1) << 6, MDROUT = 28'(1) << 7;
    localparam logic [27:0] ZHIGH = 28'(1) << 8, ZLOW = 28'(1) << 9, HIOUT = 28'(1) << 10, LOOUT = 28'(1) << 11;
    localparam logic [27:0] INPOUT = 28'(1) << 12, COUT = 28'(1) << 13, BAOUT = 28'(1) << 14, ROUT = 28'(1) << 15;
    localparam logic [27:0] PCIN = 28'(1) << 16, IRIN = 28'(1) << 17, MARIN = 28'(1) << 18, MDRIN = 28'(1) << 19;
    localparam logic [27:0] YIN = 28'(1) << 20, ZIN = 28'(1) << 21, HIIN = 28'(1) << 22, LOIN = 28'(1) << 23;
    localparam logic [27:0] RIN = 28'(1) << 24, CONN = 28'(1) << 25, OUTPIN = 28'(1) << 26;
    localparam logic [27:0] FETCH0 = PCOUT | MARIN | INCPC | ZIN;

    localparam logic [4:0] I_LD = 0, I_LDI = 1, I_ST = 2, I_ADD = 3, I_SUB = 4, I_AND = 5, I_OR = 6;
    localparam logic [4:0] I_SHR = 7, I_SHRA = 8, I_SHL = 9, I_ROR = 10, I_ROL = 11, I_ADDI = 12, I_ANDI = 13;
    localparam logic [4:0] I_ORI = 14, I_MUL = 15, I_DIV = 16, I_NEG = 17, I_NOT = 18, I_BR = 19, I_JR = 20;
    localparam logic [4:0] I_JAL = 21, I_IN = 22, I_OUT = 23, I_MFHI = 24, I_MFLO = 25, I_HALT = 27;

    typedef struct packed {logic [27:0] m; logic [4:0] o;} step_t;
    typedef struct {logic [31:0] ir; logic cf; int k; logic [27:0] m; logic [4:0] o; int len;} vec_t;

    step_t       exp_q[$];
    logic [27:0] act_m[12];
    logic [4:0]  act_o[12];
    int          act_len;
    int          n_cmp = 0, n_bad = 0;
    vec_t        tbl[14];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] alu_code(input logic [4:0] op);
        case (op)
            I_ADD, I_ADDI: return 5'd1;
            I_SUB:         return 5'd2;
            I_MUL:         return 5'd3;
            I_DIV:         return 5'd4;
            I_SHR:         return 5'd5;
            I_SHL:         return 5'd6;
            I_SHRA:        return 5'd7;
            I_ROR:         return 5'd8;
            I_ROL:         return 5'd9;
            I_AND, I_ANDI: return 5'd10;
            I_OR, I_ORI:   return 5'd11;
            I_NEG:         return 5'd12;
            I_NOT:         return 5'd15;
            default:       return 5'd0;
        endcase
    endfunction

    task automatic push(input logic [27:0] m, input logic [4:0] o);
        exp_q.push_back({m, o});
    endtask

    // Expected strobe list for each micro-step of one instruction, fetch included.
    task automatic build(input logic [4:0] op, input logic cf);
        logic [4:0] a;
        a = alu_code(op);
        exp_q.delete();
        push(FETCH0, 0); push(ZLOW | PCIN | READ | MDRIN, 0); push(MDROUT | IRIN, 0);
        case (op)
            I_ADD, I_SUB, I_AND, I_OR, I_SHR, I_SHRA, I_SHL, I_ROR, I_ROL: begin
                push(GRB | ROUT | YIN, 0); push(GRC | ROUT | ZIN, a); push(ZLOW | GRA | RIN, 0);
            end
            I_ADDI, I_ANDI, I_ORI: begin
                push(GRB | ROUT | YIN, 0); push(COUT | ZIN, a); push(ZLOW | GRA | RIN, 0);
            end
            I_MUL, I_DIV: begin
                push(GRA | ROUT | YIN, 0); push(GRB | ROUT | ZIN, a); push(ZLOW | LOIN, 0); push(ZHIGH | HIIN, 0);
            end
            I_NEG, I_NOT: begin
                push(GRB | ROUT | ZIN, a); push(ZLOW | GRA | RIN, 0);
            end
            I_LDI: begin
                push(GRB | BAOUT | YIN, 0); push(COUT | ZIN, 1); push(ZLOW | GRA | RIN, 0);
            end
            I_LD: begin
                push(GRB | BAOUT | YIN, 0); push(COUT | ZIN, 1); push(ZLOW | MARIN, 0);
                push(READ | MDRIN, 0); push(MDROUT | GRA | RIN, 0);
            end
            I_ST: begin
                push(GRB | BAOUT | YIN, 0); push(COUT | ZIN, 1); push(ZLOW | MARIN, 0);
                push(GRA | ROUT | MDRIN, 0); push(WRITE, 0);
            end
            I_BR: begin
                push(GRA | ROUT | CONN, 0); push(PCOUT | YIN, 0); push(COUT | ZIN, 1);
                push(cf ? (ZLOW | PCIN) : 28'd0, 0);
            end
            I_JR:   push(GRA | ROUT | PCIN, 0);
            I_JAL:  begin push(PCOUT | GRB | RIN, 0); push(GRA | ROUT | PCIN, 0); end
            I_IN:   push(INPOUT | GRA | RIN, 0);
            I_OUT:  push(GRA | ROUT | OUTPIN, 0);
            I_MFHI: push(HIOUT | GRA | RIN, 0);
            I_MFLO: push(LOOUT | GRA | RIN, 0);
            default: push(0, 0);
        endcase
    endtask

    // Runs one instruction starting in T0; garbage ir/con_ff during fetch, real values from T3 on.
    task automatic exec(input logic [31:0] ir_v, input logic cf);
        act_len = 0;
        for (int k = 0; k < 12; k++) begin
            ir     = (k < 3) ? $urandom : ir_v;
            con_ff = (k < 3) ? 1'($urandom) : cf;
            #1;
            if (k > 0 && incPC) break;
            act_m[k] = act;
            act_o[k] = opcode;
            act_len  = k + 1;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'h611BFFFD, 1'b0, 0, FETCH0, 5'd0, 6};
        tbl[1]  = '{32'h611BFFFD, 1'b0, 3, GRB | ROUT | YIN, 5'd0, 6};
        tbl[2]  = '{32'h611BFFFD, 1'b0, 4, COUT | ZIN, 5'd1, 6};
        tbl[3]  = '{32'h611BFFFD, 1'b0, 5, ZLOW | GRA | RIN, 5'd0, 6};
        tbl[4]  = '{32'h00800055, 1'b0, 6, READ | MDRIN, 5'd0, 8};
        tbl[5]  = '{32'h00800055, 1'b0, 7, MDROUT | GRA | RIN, 5'd0, 8};
        tbl[6]  = '{32'h98800010, 1'b1, 6, ZLOW | PCIN, 5'd0, 7};
        tbl[7]  = '{32'h98800010, 1'b0, 3, GRA | ROUT | CONN, 5'd0, 7};
        tbl[8]  = '{32'h98800010, 1'b0, 4, PCOUT | YIN, 5'd0, 7};
        tbl[9]  = '{32'h98800010, 1'b0, 5, COUT | ZIN, 5'd1, 7};
        tbl[10] = '{32'h98800010, 1'b0, 6, 28'd0, 5'd0, 7};
        tbl[11] = '{32'h79880000, 1'b0, 4, GRB | ROUT | ZIN, 5'd3, 7};
        tbl[12] = '{32'h79880000, 1'b0, 5, ZLOW | LOIN, 5'd0, 7};
        tbl[13] = '{32'h79880000, 1'b0, 6, ZHIGH | HIIN, 5'd0, 7};

        #1 clr = 1'b0;
        #2 chk("reset_async", {run, opcode, act}, {1'b1, 5'd0, 28'd0});
        tick();
        chk("reset_held", {run, opcode, act}, {1'b1, 5'd0, 28'd0});
        @(negedge clk) clr = 1'b1;
        tick();
        chk("first_t0", act, FETCH0);

        for (int i = 0; i < 14; i++) begin
            exec(tbl[i].ir, tbl[i].cf);
            chk($sformatf("vec%0d_len", i), act_len, tbl[i].len);
            chk($sformatf("vec%0d_mask", i), act_m[tbl[i].k], tbl[i].m);
            chk($sformatf("vec%0d_op", i), act_o[tbl[i].k], tbl[i].o);
        end

        for (int i = 0; i < 40; i++) begin
            logic [4:0]  op;
            logic        cf;
            logic [31:0] irv;
            op = 5'($urandom_range(0, 30));
            if (op >= I_HALT) op = op + 5'd1;
            cf  = 1'($urandom_range(0, 1));
            irv = {op, 27'($urandom)};
            build(op, cf);
            exec(irv, cf);
            chk($sformatf("rnd%0d_op%0d_len", i, op), act_len, exp_q.size());
            for (int k = 0; k < exp_q.size() && k < act_len; k++) begin
                chk($sformatf("rnd%0d_op%0d_t%0d_mask", i, op, k), act_m[k], exp_q[k].m);
                chk($sformatf("rnd%0d_op%0d_t%0d_alu", i, op, k), act_o[k], exp_q[k].o);
            end
        end

        ir = {I_HALT, 27'd0};
        tick(); tick(); tick();
        chk("halt_t3", {run, opcode, act}, {1'b1, 5'd0, 28'd0});
        tick();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("halt_hold%0d", i), {run, opcode, act}, {1'b0, 5'd0, 28'd0});
            tick();
        end
        #2 clr = 1'b0;
        #1 chk("halt_clr", {run, opcode, act}, {1'b1, 5'd0, 28'd0});
        @(negedge clk) clr = 1'b1;
        tick();
        chk("halt_exit_t0", act, FETCH0);

        ir = {I_ADD, 27'h0123456};
        tick(); tick(); tick(); tick();
        chk("add_t4", {opcode, act}, {5'd1, GRC | ROUT | ZIN});
        #2 clr = 1'b0;
        #1 chk("midreset_zin", {run, opcode, act}, {1'b1, 5'd0, 28'd0});
        tick();
        chk("midreset_idle", {run, opcode, act}, {1'b1, 5'd0, 28'd0});
        @(negedge clk) clr = 1'b1;
        tick();
        chk("midreset_t0", {PCout, MARin, act}, {1'b1, 1'b1, FETCH0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
